// File: rtl/fetch_sequencer.sv
// Program counter and fetch sequencer: drives imem_addr, captures words into IF/ID, applies stall/redirect/halt.
// Optional FETCH_PERF_EN adds saturating fetch_count / bubble_count performance counters.
module fetch_sequencer #(
  parameter int ADDR_W     = 20,
  parameter int INSTR_W    = 20,
  parameter int IMEM_DEPTH = 13,
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_plus1,
  output logic               if_id_valid,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    ifpc_q, ifpc_d;
  logic [ADDR_W-1:0]    ifpc1_q, ifpc1_d;
  logic                 vld_q, vld_d;
  logic                 pc_in_range, redir_in_range;

  assign pc_in_range    = ({1'b0, pc_q} < DEPTH_X);
  assign redir_in_range = ({1'b0, redirect_pc} < DEPTH_X);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc1_d = ifpc1_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: state_d = pc_in_range ? RUN : HALT;
      default: begin
        if (redirect_valid) begin
          // Wrong-path word in IF/ID is dropped; stall cannot hold a redirect back.
          pc_d    = redirect_pc;
          vld_d   = 1'b0;
          state_d = redir_in_range ? RUN : HALT;
        end else if (stall) begin
          state_d = state_q;
        end else if (state_q == RUN && pc_in_range) begin
          instr_d = imem_instr;
          ifpc_d  = pc_q;
          ifpc1_d = pc_q + ONE;
          vld_d   = 1'b1;
          pc_d    = pc_q + ONE;
        end else if (state_q == RUN) begin
          // PC has stepped past the last word: stop fetching.
          state_d = HALT;
          vld_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RST_PC;
      instr_q <= '0;
      ifpc_q  <= '0;
      ifpc1_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc1_q <= ifpc1_d;
      vld_q   <= vld_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus1 = ifpc1_q;
  assign if_id_valid    = vld_q;
  assign halted         = (state_q == HALT);

`ifdef FETCH_PERF_EN
  logic fetch_evt, bubble_evt;

  always_comb begin
    fetch_evt  = (state_q == RUN) && !redirect_valid && !stall && pc_in_range;
    bubble_evt = (state_q != IDLE) && !vld_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_evt && fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;
      if (bubble_evt && bubble_count != '1)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a queue scoreboard of expected fetched addresses.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [19:0] redirect_pc = '0;
  logic [19:0] imem_addr;
  logic [19:0] imem_instr;
  logic [19:0] if_id_instr;
  logic [19:0] if_id_pc;
  logic [19:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [19:0] mem_word(input logic [19:0] a);
    return {a[7:0], ~a[11:0]} ^ 20'h5A5A5;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  fetch_sequencer #(.ADDR_W(20), .INSTR_W(20), .IMEM_DEPTH(13), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic s, input logic rv, input logic [19:0] rp, input logic rn);
    @(negedge clk);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    rst_n          = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag);
    logic [19:0] a;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      a = exp_q.pop_front();
      chk({tag, "_vld"}, {31'd0, if_id_valid}, 32'd1);
      chk({tag, "_pc"}, {12'd0, if_id_pc}, {12'd0, a});
      chk({tag, "_instr"}, {12'd0, if_id_instr}, {12'd0, mem_word(a)});
      chk({tag, "_pc1"}, {12'd0, if_id_pc_plus1}, {12'd0, a + 20'd1});
    end
  endtask

  task automatic fetch(input string tag, input logic [19:0] a);
    exp_q.push_back(a);
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_word(tag);
  endtask

  task automatic check_bubble(input string tag, input logic [19:0] addr, input logic hlt);
    chk({tag, "_vld"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_addr"}, {12'd0, imem_addr}, {12'd0, addr});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, hlt});
  endtask

  initial begin
    // Reset state
    tick(1'b0, 1'b0, 20'd0, 1'b0);
    tick(1'b0, 1'b0, 20'd0, 1'b0);
    check_bubble("rst", 20'd0, 1'b0);
    chk("rst_instr", {12'd0, if_id_instr}, 32'd0);
    chk("rst_pc", {12'd0, if_id_pc}, 32'd0);
    chk("rst_pc1", {12'd0, if_id_pc_plus1}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_fcnt", fetch_count, 32'd0);
    chk("rst_bcnt", bubble_count, 32'd0);
`endif

    // IDLE edge captures nothing
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_bubble("idle", 20'd0, 1'b0);

    // Walk the whole program, then halt past the last word
    for (int a = 0; a < 13; a++) fetch("walk", 20'(a));
    chk("walk_addr13", {12'd0, imem_addr}, 32'd13);
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_bubble("halt", 20'd13, 1'b1);
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_bubble("halt_hold", 20'd13, 1'b1);
`ifdef FETCH_PERF_EN
    chk("walk_fcnt", fetch_count, 32'd13);
    chk("walk_bcnt", bubble_count, 32'd2);
`endif

    // Redirect out of HALT to word 0
    tick(1'b0, 1'b1, 20'd0, 1'b1);
    check_bubble("unhalt", 20'd0, 1'b0);
    for (int a = 0; a < 5; a++) fetch("restart", 20'(a));

    // Stall three cycles holding word 4
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 20'd0, 1'b1);
      chk("stall_vld", {31'd0, if_id_valid}, 32'd1);
      chk("stall_pc", {12'd0, if_id_pc}, 32'd4);
      chk("stall_instr", {12'd0, if_id_instr}, {12'd0, mem_word(20'd4)});
      chk("stall_addr", {12'd0, imem_addr}, 32'd5);
    end
    for (int a = 5; a < 10; a++) fetch("resume", 20'(a));
    chk("pre_redir_addr", {12'd0, imem_addr}, 32'd10);

    // Redirect at pc=10 back to 2: one bubble
    tick(1'b0, 1'b1, 20'd2, 1'b1);
    check_bubble("redir2", 20'd2, 1'b0);
    fetch("redir2_tgt", 20'd2);

    // Redirect and stall together: redirect wins
    tick(1'b1, 1'b1, 20'd7, 1'b1);
    check_bubble("redir_stall", 20'd7, 1'b0);
    fetch("redir7_tgt", 20'd7);

    // Redirect out of range from RUN halts immediately
    tick(1'b0, 1'b1, 20'd20, 1'b1);
    check_bubble("redir20", 20'd20, 1'b1);
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_bubble("redir20_hold", 20'd20, 1'b1);

    // Reach pc=6, then reset during a stall
    tick(1'b0, 1'b1, 20'd5, 1'b1);
    check_bubble("redir5", 20'd5, 1'b0);
    fetch("redir5_tgt", 20'd5);
    chk("pre_rst_addr", {12'd0, imem_addr}, 32'd6);
    tick(1'b1, 1'b0, 20'd0, 1'b0);
    check_bubble("rst_stall", 20'd0, 1'b0);
    chk("rst_stall_pc", {12'd0, if_id_pc}, 32'd0);
    tick(1'b0, 1'b0, 20'd0, 1'b1);
    check_bubble("idle2", 20'd0, 1'b0);
    fetch("post_rst", 20'd0);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
